// File: rtl/trng_osc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : trng_osc_ctrl_if
//  Purpose  : Bundles the oscillator-bank control/sample lines and the random
//             word valid/ready port of trng_osc_ctrl.
//  Signals  : en           - run rounds when 1, return to idle when 0
//             osc_t        - T input of each oscillator cell
//             osc_i1       - I1 input of each oscillator cell
//             osc_i2       - I2 input of each oscillator cell (tied low)
//             osc_in       - asynchronous OSC outputs of the cells
//             rnd_data     - random word, stable while rnd_valid=1
//             rnd_valid    - word available
//             rnd_ready    - consumer accepts the word
//             busy         - sequencer not idle
//             health_fail  - sticky stuck-bit alarm
//  Modports : slave  - controller side
//             master - consumer / cell-bank side
//  Revision : 1.0 - initial release
// ============================================================================
interface trng_osc_ctrl_if #(
    parameter int NUM_CELLS = 4,
    parameter int WORD_W    = 32
);
    logic                 en;
    logic [NUM_CELLS-1:0] osc_t;
    logic [NUM_CELLS-1:0] osc_i1;
    logic [NUM_CELLS-1:0] osc_i2;
    logic [NUM_CELLS-1:0] osc_in;
    logic [WORD_W-1:0]    rnd_data;
    logic                 rnd_valid;
    logic                 rnd_ready;
    logic                 busy;
    logic                 health_fail;

    modport slave (
        input  en,
        input  osc_in,
        input  rnd_ready,
        output osc_t,
        output osc_i1,
        output osc_i2,
        output rnd_data,
        output rnd_valid,
        output busy,
        output health_fail
    );

    modport master (
        output en,
        output osc_in,
        output rnd_ready,
        input  osc_t,
        input  osc_i1,
        input  osc_i2,
        input  rnd_data,
        input  rnd_valid,
        input  busy,
        input  health_fail
    );
endinterface
`default_nettype wire

// File: rtl/trng_osc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trng_osc_ctrl
//  Purpose  : Round sequencer for a bank of ring-oscillator cells in the TRNG.
//             Each round holds the cells in reset, arms them, lets them run
//             freely and samples them. The XOR of the synchronised cell outputs
//             is one raw bit; raw bits are packed MSB-first into words handed
//             out on a valid/ready port. A sticky flag reports a run of
//             identical raw bits reaching STUCK_LIMIT.
//  Ports    : clk  - system clock
//             rst  - asynchronous active-high reset
//             bus  - trng_osc_ctrl_if.slave (cell controls, cell outputs,
//                    word handshake, busy, health_fail)
//  Revision : 1.0 - initial release
// ============================================================================
module trng_osc_ctrl #(
    parameter int NUM_CELLS   = 4,
    parameter int RST_CYCLES  = 8,
    parameter int RUN_CYCLES  = 64,
    parameter int WORD_W      = 32,
    parameter int STUCK_LIMIT = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    trng_osc_ctrl_if.slave bus
);

    localparam int CNT_MAX  = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int BIT_W    = $clog2(WORD_W + 1);
    localparam int RUNLEN_W = $clog2(STUCK_LIMIT + 1);

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_RESET  = 3'd1;
    localparam logic [2:0] C_START  = 3'd2;
    localparam logic [2:0] C_RUN    = 3'd3;
    localparam logic [2:0] C_SAMPLE = 3'd4;
    localparam logic [2:0] C_HOLD   = 3'd5;

    logic [2:0]           state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [WORD_W-1:0]    shift_q,   shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]    data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic [RUNLEN_W-1:0]  run_len_q, run_len_d;
    logic                 last_q,    last_d;
    logic                 health_q,  health_d;
    logic [NUM_CELLS-1:0] sync1_q;
    logic [NUM_CELLS-1:0] sync2_q;

    logic                 w_raw;
    logic [WORD_W-1:0]    w_shift_in;
    logic                 w_out_free;
    logic                 w_accept;
    logic                 w_load;
    logic [WORD_W-1:0]    w_load_word;
    logic                 w_t;
    logic                 w_i1;

    assign w_raw      = ^sync2_q;
    assign w_shift_in = {shift_q[WORD_W-2:0], w_raw};
    // The output register can take a new word when empty or being drained now.
    assign w_out_free = !valid_q || bus.rnd_ready;
    assign w_accept   = valid_q && bus.rnd_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        run_len_d   = run_len_q;
        last_d      = last_q;
        health_d    = health_q;
        w_load      = 1'b0;
        w_load_word = shift_q;

        case (state_q)
            C_IDLE: begin
                if (bus.en) begin
                    state_d = C_RESET;
                    cnt_d   = '0;
                end
            end
            C_RESET: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = C_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            C_START: begin
                state_d = C_RUN;
            end
            C_RUN: begin
                if (cnt_q == CNT_W'(RUN_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = C_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            C_SAMPLE: begin
                shift_d = w_shift_in;
                // Run length of identical raw bits; zero means no bit seen yet.
                if ((run_len_q == '0) || (w_raw != last_q)) begin
                    run_len_d = RUNLEN_W'(1);
                end else if (run_len_q != RUNLEN_W'(STUCK_LIMIT)) begin
                    run_len_d = run_len_q + 1'b1;
                end
                last_d = w_raw;
                if (run_len_d == RUNLEN_W'(STUCK_LIMIT)) begin
                    health_d = 1'b1;
                end
                if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                    if (w_out_free) begin
                        w_load      = 1'b1;
                        w_load_word = w_shift_in;
                        bit_cnt_d   = '0;
                        state_d     = C_RESET;
                    end else begin
                        // Full word parked in the shift register until the
                        // consumer drains the output register.
                        bit_cnt_d = BIT_W'(WORD_W);
                        state_d   = C_HOLD;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = C_RESET;
                end
            end
            C_HOLD: begin
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_load_word = shift_q;
                    bit_cnt_d   = '0;
                    state_d     = C_RESET;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase

        // Disabling abandons the round and any partial word; the output
        // register and its handshake carry on untouched.
        if (!bus.en) begin
            state_d   = C_IDLE;
            cnt_d     = '0;
            shift_d   = '0;
            bit_cnt_d = '0;
            run_len_d = '0;
            last_d    = 1'b0;
            health_d  = 1'b0;
            w_load    = 1'b0;
        end

        if (w_load) begin
            data_d  = w_load_word;
            valid_d = 1'b1;
        end else if (w_accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= C_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            run_len_q <= '0;
            last_q    <= 1'b0;
            health_q  <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            run_len_q <= run_len_d;
            last_q    <= last_d;
            health_q  <= health_d;
            sync1_q   <= bus.osc_in;
            sync2_q   <= sync1_q;
        end
    end

    // Cell controls decode straight from the state so a reset forces them low
    // immediately.
    assign w_t  = (state_q == C_START) || (state_q == C_RUN) || (state_q == C_SAMPLE);
    assign w_i1 = (state_q == C_RUN) || (state_q == C_SAMPLE);

    assign bus.osc_t       = {NUM_CELLS{w_t}};
    assign bus.osc_i1      = {NUM_CELLS{w_i1}};
    assign bus.osc_i2      = '0;
    assign bus.rnd_data    = data_q;
    assign bus.rnd_valid   = valid_q;
    assign bus.busy        = (state_q != C_IDLE);
    assign bus.health_fail = health_q;

endmodule
`default_nettype wire

// File: tb/tb_trng_osc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trng_osc_ctrl
//  Purpose  : Self-checking bench for trng_osc_ctrl. A round-timeline model
//             (position within round, hold flag, queue of raw bits) predicts
//             every output each cycle; a vector table and hand sequences add
//             explicit checks of words, reset and back-pressure behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trng_osc_ctrl;

    localparam int NC    = 2;
    localparam int RSTC  = 2;
    localparam int RUNC  = 4;
    localparam int W     = 4;
    localparam int LIM   = 3;
    localparam int ROUND = RSTC + RUNC + 2;
    localparam int NVEC  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trng_osc_ctrl_if #(.NUM_CELLS(NC), .WORD_W(W)) bus ();

    trng_osc_ctrl #(
        .NUM_CELLS  (NC),
        .RST_CYCLES (RSTC),
        .RUN_CYCLES (RUNC),
        .WORD_W     (W),
        .STUCK_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    bit             m_active;
    bit             m_hold;
    int             m_pos;
    bit             m_bits[$];
    logic [W-1:0]   m_out;
    bit             m_valid;
    bit             m_health;
    int             m_run;
    bit             m_last;
    logic [NC-1:0]  m_d1, m_d2;   // osc_in seen one and two edges ago

    function automatic void model_reset();
        m_active = 0; m_hold = 0; m_pos = 0; m_bits.delete();
        m_out = '0; m_valid = 0; m_health = 0; m_run = 0; m_last = 0;
        m_d1 = '0; m_d2 = '0;
    endfunction

    function automatic logic [W-1:0] pack_bits();
        int v;
        v = 0;
        for (int i = 0; i < W; i++) v = v * 2 + int'(m_bits[i]);
        return W'(v);
    endfunction

    function automatic void model_step(input bit en, input bit rdy, input logic [NC-1:0] osc);
        bit raw, load, accept, free;
        logic [W-1:0] word;
        raw = ^m_d2; load = 0; word = '0;
        accept = m_valid && rdy;
        free   = !m_valid || rdy;
        if (!en) begin
            m_active = 0; m_hold = 0; m_pos = 0; m_bits.delete();
            m_run = 0; m_health = 0;
        end else if (!m_active) begin
            m_active = 1; m_pos = 0;
        end else if (m_hold) begin
            if (free) begin
                word = pack_bits(); load = 1; m_bits.delete();
                m_hold = 0; m_pos = 0;
            end
        end else if (m_pos == ROUND - 1) begin
            m_bits.push_back(raw);
            m_run  = (m_run == 0 || raw != m_last) ? 1 : m_run + 1;
            m_last = raw;
            if (m_run >= LIM) m_health = 1;
            m_pos = 0;
            if (m_bits.size() == W) begin
                if (free) begin
                    word = pack_bits(); load = 1; m_bits.delete();
                end else begin
                    m_hold = 1;
                end
            end
        end else begin
            m_pos++;
        end
        if (load) begin
            m_out = word; m_valid = 1;
        end else if (accept) begin
            m_valid = 0;
        end
        m_d2 = m_d1; m_d1 = osc;
    endfunction

    // ---------------- checking ----------------
    task automatic check_all();
        logic [NC-1:0] et, ei;
        et = {NC{m_active && !m_hold && (m_pos >= RSTC)}};
        ei = {NC{m_active && !m_hold && (m_pos >= RSTC + 1)}};
        n_vec++;
        if (bus.osc_t !== et || bus.osc_i1 !== ei || bus.osc_i2 !== '0 ||
            bus.busy !== m_active || bus.rnd_valid !== m_valid ||
            bus.rnd_data !== m_out || bus.health_fail !== m_health) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t: got t=%b i1=%b i2=%b busy=%b v=%b d=%h hf=%b, expected t=%b i1=%b i2=00 busy=%b v=%b d=%h hf=%b",
                     $time, bus.osc_t, bus.osc_i1, bus.osc_i2, bus.busy, bus.rnd_valid,
                     bus.rnd_data, bus.health_fail, et, ei, m_active, m_valid, m_out, m_health);
        end
    endtask

    task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(bus.en, bus.rnd_ready, bus.osc_in);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.en = 1'b0; bus.rnd_ready = 1'b0; bus.osc_in = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (!bus.rnd_valid && k < budget) begin
            tick(); k++;
        end
        expect_eq(name, {31'd0, bus.rnd_valid}, 32'd1);
    endtask

    typedef struct {
        logic [W*NC-1:0] osc;    // round 0 in the most significant pair
        logic [W-1:0]    word;
        logic            hf;
    } vec_t;

    vec_t vecs[NVEC];

    initial begin
        vecs[0] = '{osc: 8'b01_01_01_01, word: 4'hF, hf: 1'b1};
        vecs[1] = '{osc: 8'b01_00_01_01, word: 4'hB, hf: 1'b0};
        vecs[2] = '{osc: 8'b01_00_10_11, word: 4'hA, hf: 1'b0};
        vecs[3] = '{osc: 8'b11_00_11_00, word: 4'h0, hf: 1'b1};
        vecs[4] = '{osc: 8'b10_10_00_11, word: 4'hC, hf: 1'b0};
        vecs[5] = '{osc: 8'b00_11_11_10, word: 4'h1, hf: 1'b1};

        bus.en = 1'b0; bus.rnd_ready = 1'b0; bus.osc_in = '0;
        model_reset();

        // Reset state
        do_reset();
        expect_eq("rst_busy",   {31'd0, bus.busy}, 0);
        expect_eq("rst_osc_t",  {30'd0, bus.osc_t}, 0);
        expect_eq("rst_osc_i1", {30'd0, bus.osc_i1}, 0);
        expect_eq("rst_valid",  {31'd0, bus.rnd_valid}, 0);
        expect_eq("rst_data",   {28'd0, bus.rnd_data}, 0);
        expect_eq("rst_health", {31'd0, bus.health_fail}, 0);

        // Word vectors
        for (int i = 0; i < NVEC; i++) begin
            do_reset();
            bus.en = 1'b1; bus.rnd_ready = 1'b1;
            for (int r = 0; r < W; r++) begin
                bus.osc_in = vecs[i].osc[(W-1-r)*NC +: NC];
                repeat (ROUND) tick();
            end
            wait_valid("vec_valid", ROUND);
            expect_eq("vec_data",   {28'd0, bus.rnd_data}, {28'd0, vecs[i].word});
            expect_eq("vec_health", {31'd0, bus.health_fail}, {31'd0, vecs[i].hf});
        end

        // Async reset in the middle of RUN with a word pending
        do_reset();
        bus.en = 1'b1; bus.rnd_ready = 1'b0; bus.osc_in = 2'b01;
        repeat (4 * ROUND + 1) tick();
        repeat (4) tick();
        expect_eq("pre_rst_t",     {30'd0, bus.osc_t}, 32'h3);
        expect_eq("pre_rst_valid", {31'd0, bus.rnd_valid}, 1);
        #2 rst = 1'b1;
        #1;
        expect_eq("async_t",      {30'd0, bus.osc_t}, 0);
        expect_eq("async_i1",     {30'd0, bus.osc_i1}, 0);
        expect_eq("async_valid",  {31'd0, bus.rnd_valid}, 0);
        expect_eq("async_busy",   {31'd0, bus.busy}, 0);
        expect_eq("async_health", {31'd0, bus.health_fail}, 0);
        model_reset();
        bus.en = 1'b0;
        tick();
        rst = 1'b0;

        // Back-pressure: two words, second parks in HOLD
        do_reset();
        bus.en = 1'b1; bus.rnd_ready = 1'b0; bus.osc_in = 2'b01;
        repeat (4 * ROUND) tick();
        bus.osc_in = 2'b00;
        repeat (5 * ROUND) tick();
        expect_eq("hold_valid", {31'd0, bus.rnd_valid}, 1);
        expect_eq("hold_data",  {28'd0, bus.rnd_data}, 32'hF);
        expect_eq("hold_t",     {30'd0, bus.osc_t}, 0);
        expect_eq("hold_busy",  {31'd0, bus.busy}, 1);
        bus.rnd_ready = 1'b1;
        tick();
        expect_eq("reload_valid", {31'd0, bus.rnd_valid}, 1);
        expect_eq("reload_data",  {28'd0, bus.rnd_data}, 0);
        bus.rnd_ready = 1'b0;
        tick(); tick();
        expect_eq("resume_t",  {30'd0, bus.osc_t}, 32'h3);
        expect_eq("resume_i1", {30'd0, bus.osc_i1}, 0);

        // Disable after two bits, then re-enable
        do_reset();
        bus.en = 1'b1; bus.rnd_ready = 1'b1; bus.osc_in = 2'b01;
        repeat (2 * ROUND + 1) tick();
        bus.en = 1'b0;
        tick();
        expect_eq("dis_busy",   {31'd0, bus.busy}, 0);
        expect_eq("dis_health", {31'd0, bus.health_fail}, 0);
        bus.en = 1'b1;
        for (int r = 0; r < W; r++) begin
            bus.osc_in = (r < 2) ? 2'b01 : 2'b00;
            repeat (ROUND) tick();
        end
        wait_valid("reen_valid", ROUND);
        expect_eq("reen_data",   {28'd0, bus.rnd_data}, 32'hC);
        expect_eq("reen_health", {31'd0, bus.health_fail}, 0);

        // Randomised traffic against the model
        do_reset();
        bus.en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.osc_in = NC'($urandom);
            bus.rnd_ready = ($urandom_range(0, 9) < 6);
            bus.en = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
